// File: rtl/bramac_inst_seq.sv
// bramac_inst_seq: turns a job descriptor plus a stream of activation
// pairs into the cycle-by-cycle BrAMAC instruction words for the
// downstream compute-mode FSM. The instruction word and status flags are
// registers; each one is loaded with the value that belongs to the state
// being entered, so it always describes the current state.
module bramac_inst_seq #(
    parameter int DWIDTH = 40
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_job_valid,
    output logic              o_job_ready,
    input  logic [1:0]        i_job_mode,
    input  logic [7:0]        i_job_npairs,
    input  logic [6:0]        i_job_row_base,
    input  logic [1:0]        i_job_col_1,
    input  logic [1:0]        i_job_col_2,
    input  logic              i_job_reload,
    input  logic              i_act_valid,
    output logic              o_act_ready,
    input  logic [15:0]       i_act_data,
    output logic              o_comp_en,
    output logic [DWIDTH-1:0] o_inst,
    output logic              o_busy,
    output logic              o_job_done,
    output logic              o_err_cfg,
    output logic              o_err_underflow
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_RST   = 4'd1;
    localparam logic [3:0] S_START = 4'd2;
    localparam logic [3:0] S_MODE  = 4'd3;
    localparam logic [3:0] S_LDW1  = 4'd4;
    localparam logic [3:0] S_LDW2  = 4'd5;
    localparam logic [3:0] S_RUN   = 4'd6;
    localparam logic [3:0] S_DRAIN = 4'd7;
    localparam logic [3:0] S_CLR   = 4'd8;

    // Strobe patterns, ordered {reset, start, done, copy_en}
    localparam logic [3:0] STB_NONE  = 4'b0000;
    localparam logic [3:0] STB_RESET = 4'b1000;
    localparam logic [3:0] STB_START = 4'b0100;
    localparam logic [3:0] STB_DONE  = 4'b0010;

    logic [3:0]        r_state;
    logic              r_bufFull;
    logic [15:0]       r_bufData;
    logic [1:0]        r_mode;
    logic [1:0]        r_col1;
    logic [1:0]        r_col2;
    logic              r_reload;
    logic [6:0]        r_row;
    logic [7:0]        r_left;
    logic [3:0]        r_ph;
    logic              r_starved;
    logic [DWIDTH-1:0] r_inst;
    logic              r_compEn;
    logic              r_busy;
    logic              r_jobDone;
    logic              r_errCfg;
    logic              r_errUnderflow;

    logic              w_jobFire;
    logic              w_actFire;
    logic              w_jobIllegal;
    logic              w_isLast;
    logic [3:0]        w_phP;
    logic [3:0]        w_phAdd;
    logic [3:0]        w_phAcc;
    logic [7:0]        w_a1;
    logic [7:0]        w_a2;
    logic [DWIDTH-1:0] w_cfg;

    // Strobes, row and input byte; mode/col fields are OR-ed in separately
    function automatic logic [DWIDTH-1:0] mkInst(input logic [3:0] strobes,
                                                 input logic [6:0] row,
                                                 input logic [7:0] din);
        logic [DWIDTH-1:0] v;
        v        = '0;
        v[24:21] = strobes;
        v[18:12] = row;
        v[7:0]   = din;
        return v;
    endfunction

    function automatic logic [DWIDTH-1:0] mkCfg(input logic [1:0] mode,
                                                input logic [1:0] col1,
                                                input logic [1:0] col2);
        logic [DWIDTH-1:0] v;
        v        = '0;
        v[20:19] = mode;
        v[11:10] = col1;
        v[9:8]   = col2;
        return v;
    endfunction

    // Activations arrive right-aligned; the array wants them left-aligned
    function automatic logic [7:0] alignAct(input logic [1:0] mode,
                                            input logic [7:0] a);
        case (mode)
            2'b01:   return {a[1:0], 6'b0};
            2'b10:   return {a[3:0], 4'b0};
            default: return a;
        endcase
    endfunction

    assign w_jobFire    = i_job_valid && o_job_ready;
    assign w_actFire    = i_act_valid && o_act_ready;
    assign w_jobIllegal = (i_job_mode == 2'b00) || (i_job_npairs == 8'd0);
    assign w_isLast     = (r_left == 8'd0);
    assign w_phAdd      = w_phP + 4'd1;
    assign w_phAcc      = w_phP + 4'd2;
    assign w_a1         = alignAct(r_mode, r_bufData[7:0]);
    assign w_a2         = alignAct(r_mode, r_bufData[15:8]);
    assign w_cfg        = mkCfg(r_mode, r_col1, r_col2);

    assign o_job_ready     = (r_state == S_IDLE) && r_bufFull && !i_reset;
    assign o_act_ready     = !r_bufFull && !i_reset;
    assign o_inst          = r_inst;
    assign o_comp_en       = r_compEn;
    assign o_busy          = r_busy;
    assign o_job_done      = r_jobDone;
    assign o_err_cfg       = r_errCfg;
    assign o_err_underflow = r_errUnderflow;

    // Bit precision of the running job sets the number of MAC phases per pair
    always_comb begin
        w_phP = 4'd8;
        case (r_mode)
            2'b01:   w_phP = 4'd2;
            2'b10:   w_phP = 4'd4;
            default: w_phP = 4'd8;
        endcase
    end

    // Sequencer: state, activation buffer and next-state instruction word
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= S_IDLE;
            r_bufFull      <= 1'b0;
            r_bufData      <= '0;
            r_mode         <= '0;
            r_col1         <= '0;
            r_col2         <= '0;
            r_reload       <= 1'b0;
            r_row          <= '0;
            r_left         <= '0;
            r_ph           <= '0;
            r_starved      <= 1'b0;
            r_inst         <= '0;
            r_compEn       <= 1'b0;
            r_busy         <= 1'b0;
            r_jobDone      <= 1'b0;
            r_errCfg       <= 1'b0;
            r_errUnderflow <= 1'b0;
        end else begin
            r_jobDone <= 1'b0;
            if (w_actFire) begin
                r_bufFull <= 1'b1;
                r_bufData <= i_act_data;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_jobFire) begin
                        if (w_jobIllegal) begin
                            r_errCfg <= 1'b1;
                        end else begin
                            r_mode    <= i_job_mode;
                            r_col1    <= i_job_col_1;
                            r_col2    <= i_job_col_2;
                            r_reload  <= i_job_reload;
                            r_row     <= i_job_row_base;
                            r_left    <= i_job_npairs - 8'd1;
                            r_ph      <= '0;
                            r_starved <= 1'b0;
                            r_compEn  <= 1'b1;
                            r_busy    <= 1'b1;
                            r_state   <= S_RST;
                            r_inst    <= mkInst(STB_RESET, i_job_row_base, 8'h00)
                                         | mkCfg(i_job_mode, i_job_col_1, i_job_col_2);
                        end
                    end
                end
                S_RST: begin
                    r_state <= S_START;
                    r_inst  <= mkInst(STB_START, r_row, 8'h00) | w_cfg;
                end
                S_START: begin
                    r_state <= S_MODE;
                    r_inst  <= mkInst(STB_NONE, r_row, 8'h00) | w_cfg;
                end
                S_MODE: begin
                    r_state <= S_LDW1;
                    r_inst  <= mkInst(STB_NONE, r_row, w_a1) | w_cfg;
                end
                S_LDW1: begin
                    r_state <= S_LDW2;
                    r_inst  <= mkInst(STB_NONE, r_row + 7'd1, w_a2) | w_cfg;
                end
                S_LDW2: begin
                    r_state   <= S_RUN;
                    r_ph      <= '0;
                    r_bufFull <= 1'b0;
                    r_inst    <= mkInst(STB_NONE, r_row, 8'h00) | w_cfg;
                end
                S_RUN: begin
                    if (r_ph == w_phAcc) begin
                        if (w_isLast) begin
                            r_state <= S_DRAIN;
                            r_inst  <= mkInst(STB_NONE, r_row, 8'h00) | w_cfg;
                        end else begin
                            r_ph      <= '0;
                            r_row     <= r_row + 7'd2;
                            r_left    <= r_left - 8'd1;
                            r_starved <= 1'b0;
                            if (!r_starved) begin
                                r_bufFull <= 1'b0;
                            end
                            r_inst <= mkInst(STB_NONE, r_row + 7'd2, 8'h00) | w_cfg;
                        end
                    end else if (r_ph == w_phP) begin
                        r_ph <= r_ph + 4'd1;
                        if (w_isLast) begin
                            r_inst <= mkInst(STB_NONE, r_row, 8'h00) | w_cfg;
                        end else if (r_bufFull) begin
                            r_inst <= mkInst({3'b000, r_reload}, r_row + 7'd2, w_a1) | w_cfg;
                        end else begin
                            r_starved      <= 1'b1;
                            r_errUnderflow <= 1'b1;
                            r_inst <= mkInst({3'b000, r_reload}, r_row + 7'd2, 8'h00) | w_cfg;
                        end
                    end else if (r_ph == w_phAdd) begin
                        r_ph <= r_ph + 4'd1;
                        if (w_isLast) begin
                            r_inst <= mkInst(STB_DONE, r_row, 8'h00) | w_cfg;
                        end else begin
                            r_inst <= mkInst(STB_NONE, r_row + 7'd3,
                                             r_starved ? 8'h00 : w_a2) | w_cfg;
                        end
                    end else begin
                        r_ph   <= r_ph + 4'd1;
                        r_inst <= mkInst(STB_NONE, r_row, 8'h00) | w_cfg;
                    end
                end
                S_DRAIN: begin
                    r_state   <= S_CLR;
                    r_jobDone <= 1'b1;
                    r_inst    <= mkInst(STB_RESET, r_row, 8'h00) | w_cfg;
                end
                S_CLR: begin
                    r_state  <= S_IDLE;
                    r_inst   <= '0;
                    r_compEn <= 1'b0;
                    r_busy   <= 1'b0;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_inst   <= '0;
                    r_compEn <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bramac_inst_seq.sv
// tb_bramac_inst_seq: drives jobs and activation pairs into the sequencer
// and checks every cycle of every job against a timeline computed from the
// job parameters.
module tb_bramac_inst_seq;

    localparam int DW = 40;

    logic          clk = 1'b0;
    logic          reset;
    logic          jobValid;
    logic          jobReady;
    logic [1:0]    jobMode;
    logic [7:0]    jobNpairs;
    logic [6:0]    jobRowBase;
    logic [1:0]    jobCol1;
    logic [1:0]    jobCol2;
    logic          jobReload;
    logic          actValid;
    logic          actReady;
    logic [15:0]   actData;
    logic          compEn;
    logic [DW-1:0] inst;
    logic          busy;
    logic          jobDone;
    logic          errCfg;
    logic          errUnderflow;

    int testsRun    = 0;
    int testsFailed = 0;

    // Pairs waiting to be offered on the act port, and pairs already offered
    // that belong to a job not yet started
    logic [15:0] actQ[$];
    logic [15:0] pushed[$];

    // Expected sticky error flags
    bit errUExp = 1'b0;
    bit errCExp = 1'b0;

    always #5 clk = ~clk;

    bramac_inst_seq #(.DWIDTH(DW)) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_job_valid     (jobValid),
        .o_job_ready     (jobReady),
        .i_job_mode      (jobMode),
        .i_job_npairs    (jobNpairs),
        .i_job_row_base  (jobRowBase),
        .i_job_col_1     (jobCol1),
        .i_job_col_2     (jobCol2),
        .i_job_reload    (jobReload),
        .i_act_valid     (actValid),
        .o_act_ready     (actReady),
        .i_act_data      (actData),
        .o_comp_en       (compEn),
        .o_inst          (inst),
        .o_busy          (busy),
        .o_job_done      (jobDone),
        .o_err_cfg       (errCfg),
        .o_err_underflow (errUnderflow)
    );

    // Single comparison point: counts the check and reports any mismatch
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Precision P = 2^mode; an activation is shifted up by 8-P and truncated
    function automatic int al(input int mode, input int a);
        return ((a & 255) << (8 - (1 << mode))) & 255;
    endfunction

    // Activation feeder: offers the head of actQ and retires it once taken
    initial begin
        bit fire;
        actValid = 1'b0;
        actData  = '0;
        forever begin
            @(negedge clk);
            fire = actValid && actReady;
            @(posedge clk);
            #1;
            if (fire) void'(actQ.pop_front());
            actValid = (actQ.size() > 0);
            actData  = actValid ? actQ[0] : 16'h0;
        end
    end

    // Offer a job and wait (bounded) for the transfer edge
    task automatic offerJob(input logic [1:0] mode, input int n, input logic [6:0] base,
                            input logic [1:0] c1, input logic [1:0] c2, input logic rl,
                            output bit accepted);
        int guard;
        jobMode    = mode;
        jobNpairs  = 8'(n);
        jobRowBase = base;
        jobCol1    = c1;
        jobCol2    = c2;
        jobReload  = rl;
        jobValid   = 1'b1;
        accepted   = 1'b0;
        guard      = 0;
        while (!accepted && guard < 200) begin
            @(negedge clk);
            accepted = jobReady;
            guard++;
            @(posedge clk);
            #1;
        end
        jobValid = 1'b0;
        checkOutput("job accepted", 64'(accepted), 64'd1);
    endtask

    // Runs one legal job and checks every cycle from RST to the first IDLE
    // cycle. Only the first 'avail' pairs are ever offered; 'extra' pairs
    // are offered for the next job. abortAt>0 pulses reset in that cycle.
    task automatic applyStimulus(input logic [1:0] mode, input int n, input logic [6:0] base,
                                 input logic [1:0] c1, input logic [1:0] c2, input logic rl,
                                 input int avail, input int extra,
                                 input logic [15:0] p0, input bit p0Fixed, input int abortAt);
        logic [15:0] pairs[$];
        logic [15:0] v;
        bit   accepted;
        int   p, busyLen, r, k, ph;
        int   expRow, expDin;
        bit   careRow, careDin, last;
        logic [3:0] expStb;
        for (int i = 0; i < n; i++) begin
            if (i < avail) begin
                if (pushed.size() > 0) begin
                    v = pushed.pop_front();
                end else begin
                    v = (i == 0 && p0Fixed) ? p0 : 16'($urandom);
                    actQ.push_back(v);
                end
            end else begin
                v = 16'h0;
            end
            pairs.push_back(v);
        end
        for (int e = 0; e < extra; e++) begin
            v = 16'($urandom);
            actQ.push_back(v);
            pushed.push_back(v);
        end
        offerJob(mode, n, base, c1, c2, rl, accepted);
        if (!accepted) return;

        p       = 1 << mode;
        busyLen = 7 + n * (p + 3);
        for (int d = 1; d <= busyLen + 1; d++) begin
            expStb  = 4'b0000;
            careRow = 1'b0;
            careDin = 1'b0;
            expRow  = 0;
            expDin  = 0;
            if (d == 1 || d == busyLen) expStb[3] = 1'b1;
            if (d == 2) expStb[2] = 1'b1;
            if (d == 4) begin
                careRow = 1'b1; careDin = 1'b1;
                expRow  = base;
                expDin  = al(mode, pairs[0][7:0]);
            end
            if (d == 5) begin
                careRow = 1'b1; careDin = 1'b1;
                expRow  = (base + 1) % 128;
                expDin  = al(mode, pairs[0][15:8]);
            end
            if (d >= 6 && d < 6 + n * (p + 3)) begin
                r    = d - 6;
                k    = r / (p + 3);
                ph   = r % (p + 3);
                last = (k == n - 1);
                if (ph == p + 1) begin
                    careDin = 1'b1;
                    if (!last) begin
                        careRow   = 1'b1;
                        expRow    = (base + 2 * (k + 1)) % 128;
                        expDin    = (k + 1 < avail) ? al(mode, pairs[k + 1][7:0]) : 0;
                        expStb[0] = rl;
                        if (k + 1 >= avail) errUExp = 1'b1;
                    end
                end
                if (ph == p + 2) begin
                    careDin = 1'b1;
                    if (last) begin
                        expStb[1] = 1'b1;
                    end else begin
                        careRow = 1'b1;
                        expRow  = (base + 2 * (k + 1) + 1) % 128;
                        expDin  = (k + 1 < avail) ? al(mode, pairs[k + 1][15:8]) : 0;
                    end
                end
            end

            if (d == abortAt) begin
                reset = 1'b1;
                @(negedge clk);
                checkOutput("job_ready in reset", 64'(jobReady), 64'd0);
                checkOutput("act_ready in reset", 64'(actReady), 64'd0);
                @(posedge clk);
                #1;
                reset = 1'b0;
                errUExp = 1'b0;
                errCExp = 1'b0;
                @(negedge clk);
                checkOutput("abort inst", 64'(inst), 64'd0);
                checkOutput("abort busy", 64'(busy), 64'd0);
                checkOutput("abort comp_en", 64'(compEn), 64'd0);
                checkOutput("abort job_done", 64'(jobDone), 64'd0);
                checkOutput("abort err_cfg", 64'(errCfg), 64'd0);
                checkOutput("abort err_underflow", 64'(errUnderflow), 64'd0);
                @(posedge clk);
                #1;
                return;
            end

            @(negedge clk);
            if (d <= busyLen) begin
                checkOutput($sformatf("d%0d busy", d), 64'(busy), 64'd1);
                checkOutput($sformatf("d%0d comp_en", d), 64'(compEn), 64'd1);
                checkOutput($sformatf("d%0d job_done", d), 64'(jobDone), 64'(d == busyLen));
                checkOutput($sformatf("d%0d strobes", d), 64'(inst[24:21]), 64'(expStb));
                checkOutput($sformatf("d%0d mode/cols", d),
                            64'({inst[20:19], inst[11:10], inst[9:8]}), 64'({mode, c1, c2}));
                checkOutput($sformatf("d%0d upper", d), 64'(inst[DW-1:25]), 64'd0);
                checkOutput($sformatf("d%0d job_ready", d), 64'(jobReady), 64'd0);
                if (careRow) checkOutput($sformatf("d%0d row", d), 64'(inst[18:12]), 64'(expRow));
                if (careDin) checkOutput($sformatf("d%0d input", d), 64'(inst[7:0]), 64'(expDin));
            end else begin
                checkOutput("idle busy", 64'(busy), 64'd0);
                checkOutput("idle comp_en", 64'(compEn), 64'd0);
                checkOutput("idle inst", 64'(inst), 64'd0);
                checkOutput("idle job_ready", 64'(jobReady), 64'(pushed.size() > 0));
                checkOutput("err_cfg", 64'(errCfg), 64'(errCExp));
                checkOutput("err_underflow", 64'(errUnderflow), 64'(errUExp));
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Illegal job: swallowed, flags err_cfg, nothing issued, buffer kept
    task automatic applyIllegal(input logic [1:0] mode, input int n);
        logic [15:0] v;
        bit accepted;
        if (pushed.size() == 0) begin
            v = 16'($urandom);
            actQ.push_back(v);
            pushed.push_back(v);
        end
        offerJob(mode, n, 7'h22, 2'd1, 2'd3, 1'b0, accepted);
        if (!accepted) return;
        errCExp = 1'b1;
        for (int d = 1; d <= 3; d++) begin
            @(negedge clk);
            checkOutput($sformatf("illegal d%0d comp_en", d), 64'(compEn), 64'd0);
            checkOutput($sformatf("illegal d%0d busy", d), 64'(busy), 64'd0);
            checkOutput($sformatf("illegal d%0d inst", d), 64'(inst), 64'd0);
            checkOutput($sformatf("illegal d%0d err_cfg", d), 64'(errCfg), 64'd1);
            checkOutput($sformatf("illegal d%0d job_ready", d), 64'(jobReady), 64'd1);
            @(posedge clk);
            #1;
        end
    endtask

    // Safety net so a stuck design cannot hang the run
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    // Main sequence: reset, directed jobs, random jobs, error cases, abort
    initial begin
        int m, n, avail;
        reset      = 1'b1;
        jobValid   = 1'b0;
        jobMode    = '0;
        jobNpairs  = '0;
        jobRowBase = '0;
        jobCol1    = '0;
        jobCol2    = '0;
        jobReload  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset job_ready", 64'(jobReady), 64'd0);
        checkOutput("reset act_ready", 64'(actReady), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset inst", 64'(inst), 64'd0);
        checkOutput("reset comp_en", 64'(compEn), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset job_done", 64'(jobDone), 64'd0);
        checkOutput("reset err_cfg", 64'(errCfg), 64'd0);
        checkOutput("reset err_underflow", 64'(errUnderflow), 64'd0);
        checkOutput("reset act_ready after", 64'(actReady), 64'd1);
        @(posedge clk);
        #1;

        // 2-bit job with pair {02,03}, then 8-bit job {5A,C3} at base 0x10
        applyStimulus(2'b01, 1, 7'h05, 2'd3, 2'd0, 1'b0, 1, 0, 16'h0203, 1'b1, 0);
        applyStimulus(2'b11, 1, 7'h10, 2'd1, 2'd2, 1'b0, 1, 1, 16'h5AC3, 1'b1, 0);

        // Illegal mode and illegal pair count with a pair parked in the buffer
        applyIllegal(2'b00, 3);
        applyIllegal(2'b10, 0);

        // 4-bit two-pair job wrapping the row address, with reload
        applyStimulus(2'b10, 2, 7'h7E, 2'd2, 2'd1, 1'b1, 2, 0, 16'h0, 1'b0, 0);

        for (int i = 0; i < 12; i++) begin
            m     = $urandom_range(1, 3);
            n     = (i == 5) ? $urandom_range(10, 20) : $urandom_range(1, 4);
            avail = (i % 4 == 3) ? $urandom_range(1, n) : n;
            applyStimulus(2'(m), n, 7'($urandom_range(0, 127)), 2'($urandom_range(0, 3)),
                          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          avail, 0, 16'h0, 1'b0, 0);
        end

        // Second pair withheld: underflow but the job still completes
        applyStimulus(2'b10, 2, 7'h40, 2'd0, 2'd3, 1'b1, 1, 0, 16'h0, 1'b0, 0);

        // Reset during RUN phase 3, then the reference job again
        applyStimulus(2'b11, 1, 7'h10, 2'd1, 2'd2, 1'b0, 1, 0, 16'h5AC3, 1'b1, 9);
        applyStimulus(2'b11, 1, 7'h10, 2'd1, 2'd2, 1'b0, 1, 0, 16'h5AC3, 1'b1, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/bramac_inst_seq.md
BRAMAC_INST_SEQ -- requirements
Module: bramac_inst_seq

Interface
REQ-001 Parameter: DWIDTH, default 40, width of the BrAMAC instruction word.
REQ-002 clk  in  1  single clock; all logic on posedge clk.
REQ-003 reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
REQ-004 job_valid/job_ready  in/out  1/1  job handshake; transfer when both are high.
REQ-005 job_mode  in  2  precision: 01=2b, 10=4b, 11=8b, 00=illegal.
REQ-006 job_npairs  in  8  activation pairs in the job, 1..255; 0 is illegal.
REQ-007 job_row_base  in  7  BRAM row holding W1 of pair 0.
REQ-008 job_col_1, job_col_2  in  2 each  BRAM column selects, constant for the whole job.
REQ-009 job_reload  in  1  reload W1 via copy_en between pairs.
REQ-010 act_valid/act_ready  in/out  1/1  activation-pair handshake.
REQ-011 act_data  in  16  {a2[15:8], a1[7:0]}; significant bits right-aligned.
REQ-012 comp_en  out  1  compute-mode enable to the downstream instruction FSM.
REQ-013 inst  out  DWIDTH  fields: [24] reset, [23] start, [22] done, [21] copy_en, [20:19] mode, [18:12] row, [11:10] col1, [9:8] col2, [7:0] input; [39:25] zero.
REQ-014 busy, job_done, err_cfg, err_underflow  out  1 each  status; job_done is a 1-cycle pulse; both err_* are sticky.

Function
REQ-015 Single-entry activation-pair buffer; act_ready = buffer empty; a pair loads on handshake.
REQ-016 job_ready = IDLE && buffer full && !reset.
REQ-017 Illegal job (mode 00 or npairs 0): accepted, discarded, err_cfg set, no instruction issued, stays IDLE.
REQ-018 States: IDLE, RST, START, MODE, LDW1, LDW2, RUN, DRAIN, CLR; legal job accepted at cycle T -> RST at T+1, then one cycle per state up to RUN.
REQ-019 RST: inst[24]=1. START: inst[23]=1. MODE: no strobes; mode field driven.
REQ-020 LDW1: input=a1 of pair 0, row=base. LDW2: input=a2, row=base+1; buffer freed at end of LDW2.
REQ-021 RUN per pair: phase counter ph 0..P+2 (P=2/4/8), i.e. P+3 cycles; ph=P+1 is ADD, ph=P+2 is ACC.
REQ-022 ADD of pair k (not last): input=a1 of pair k+1, row=base+2(k+1), copy_en=job_reload; buffer supplies a1.
REQ-023 ACC of pair k (not last): input=a2 of pair k+1, row=base+2(k+1)+1; buffer freed at end of ACC; ph returns to 0.
REQ-024 Last pair: ADD with input=0, copy_en=0; ACC with input=0, done=1; then DRAIN (1 cycle), CLR (inst[24]=1, job_done=1), then IDLE.
REQ-025 Buffer empty at a non-last ADD: input=0 in ADD and ACC, err_underflow set, pair counted consumed, no stall.
REQ-026 Input left-aligned: input = act << (8-P), truncated to 8 bits.
REQ-027 Row arithmetic is modulo 128 (wraps 7F->00).
REQ-028 Mode/col fields hold job values in all states RST..CLR.
REQ-029 comp_en=1 and busy=1 in states RST..CLR, else 0.
REQ-030 In IDLE, inst=0.
REQ-031 Registered outputs: inst/comp_en reflect the current state, not the next.

Reset
REQ-032 Reset values: inst=0, comp_en=0, busy=0, job_done=0, err_*=0, buffer empty, state IDLE; job_ready=0 and act_ready=0 during the reset cycle.
REQ-033 Reset mid-job aborts with no job_done; the downstream FSM is left as-is and cleared by the next job's RST cycle.

Verification
REQ-034 Mode 11, npairs=1, base=0x10, pair {5A,C3}, accepted at T:
 - T+1 reset; T+2 start.
 - T+4 input=C3, row=10; T+5 input=5A, row=11.
 - ACC done=1 at T+16; CLR + job_done at T+18; job_ready at T+19.
REQ-035 Mode 01, pair {02,03}: LDW1 input=C0, LDW2 input=80; RUN is 5 cycles per pair.
REQ-036 Mode 10, npairs=2, base=0x7E, reload=1:
 - pair 0 rows 7E/7F; pair 1 rows 00/01.
 - copy_en=1 only in pair-0 ADD; done only in pair-1 ACC.
REQ-037 Withhold the second pair: err_underflow=1, input=00 in ADD/ACC, job still completes with job_done.
REQ-038 job_mode=00: err_cfg=1, comp_en stays 0, buffer remains full.
REQ-039 Reset at RUN ph=3: next cycle inst=0, busy=0; the next job runs the REQ-034 timing exactly.
